// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, letter codes and the A-H symbol table
// (pattern MSB = first symbol, 1 = dash; length = number of symbols).
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } morse_state_e;

  localparam int unsigned MAX_SYMS = 4;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  localparam logic [3:0] PAT_A = 4'b0100;
  localparam logic [3:0] PAT_B = 4'b1000;
  localparam logic [3:0] PAT_C = 4'b1010;
  localparam logic [3:0] PAT_D = 4'b1000;
  localparam logic [3:0] PAT_E = 4'b0000;
  localparam logic [3:0] PAT_F = 4'b0010;
  localparam logic [3:0] PAT_G = 4'b1100;
  localparam logic [3:0] PAT_H = 4'b0000;

  localparam logic [2:0] LEN_A = 3'd2;
  localparam logic [2:0] LEN_B = 3'd4;
  localparam logic [2:0] LEN_C = 3'd4;
  localparam logic [2:0] LEN_D = 3'd3;
  localparam logic [2:0] LEN_E = 3'd1;
  localparam logic [2:0] LEN_F = 3'd4;
  localparam logic [2:0] LEN_G = 3'd3;
  localparam logic [2:0] LEN_H = 3'd4;

endpackage

// File: rtl/morse_match.sv
// Combinational inverse of the encoder letter table: (pattern, length) -> (letter, hit).
module morse_match
  import morse_pkg::*;
(
  input  logic [3:0] pattern_i,
  input  logic [2:0] len_i,
  output logic [2:0] letter_o,
  output logic       hit_o
);

  always_comb begin
    letter_o = '0;
    hit_o    = 1'b1;
    // Length is part of the key: E and H share the all-dot pattern.
    case ({pattern_i, len_i})
      {PAT_A, LEN_A}: letter_o = LTR_A;
      {PAT_B, LEN_B}: letter_o = LTR_B;
      {PAT_C, LEN_C}: letter_o = LTR_C;
      {PAT_D, LEN_D}: letter_o = LTR_D;
      {PAT_E, LEN_E}: letter_o = LTR_E;
      {PAT_F, LEN_F}: letter_o = LTR_F;
      {PAT_G, LEN_G}: letter_o = LTR_G;
      {PAT_H, LEN_H}: letter_o = LTR_H;
      default:        hit_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse key receiver: times presses/gaps, collects up to 4 symbols, decodes A-H.
// Define MORSE_SYNC_EN to pass key_in through a 2-flop synchronizer first.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned DASH_TICKS  = 2,
  parameter int unsigned GAP_TICKS   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  localparam int unsigned CYC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_CYCLES - 1);
  localparam logic [2:0]       DASH_MIN = 3'(DASH_TICKS);
  localparam logic [2:0]       GAP_LAST = 3'(GAP_TICKS - 1);

  logic key_s;

`ifdef MORSE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], key_in};
  end
  assign key_s = sync_q[1];
`else
  assign key_s = key_in;
`endif

  morse_state_e     state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       dur_q, dur_d;
  logic [3:0]       pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       letter_q, letter_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  logic       tick;
  logic       sym;
  logic [1:0] slot;
  logic [2:0] match_letter;
  logic       match_hit;

  morse_match u_match (
    .pattern_i (pat_q),
    .len_i     (len_q),
    .letter_o  (match_letter),
    .hit_o     (match_hit)
  );

  assign tick = (cyc_q == CYC_LAST);
  assign sym  = (dur_q >= DASH_MIN);
  assign slot = 2'(3'd3 - len_q);

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // A press in the DONE cycle starts the next letter without visiting IDLE.
        if (key_s) begin
          state_d = PRESS;
          pat_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS: begin
        if (!key_s) begin
          state_d = GAP;
          if (len_q == 3'(MAX_SYMS)) begin
            ovf_d = 1'b1;
          end else begin
            pat_d[slot] = sym;
            len_d       = len_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (key_s) begin
          state_d = PRESS;
        end else if (tick && (dur_q == GAP_LAST)) begin
          state_d = DONE;
          if (match_hit && !ovf_q) begin
            letter_d = match_letter;
            valid_d  = 1'b1;
          end else begin
            error_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // Timebase restarts on every state change, so a tick coinciding with a key edge is dropped.
  always_comb begin
    cyc_d = tick ? '0 : cyc_q + CYC_W'(1);
    dur_d = (tick && (dur_q != 3'd7)) ? dur_q + 3'd1 : dur_q;
    if (state_d != state_q) begin
      cyc_d = '0;
      dur_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      dur_q    <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      dur_q    <= dur_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign letter = letter_q;
  assign valid  = valid_q;
  assign error  = error_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: vector table, corner sequences and
// random letters against a run-length/string-table reference model.
module tb_morse_decoder;

  localparam int unsigned T       = 4;
  localparam int unsigned DASH    = 2;
  localparam int unsigned GAPT    = 3;
  localparam int unsigned END_RUN = GAPT * T + 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       key_in   = 1'b0;
  logic [2:0] letter;
  logic       valid;
  logic       error;
  logic       busy;

  always #5 CLOCK_50 = ~CLOCK_50;

  morse_decoder #(
    .TICK_CYCLES (T),
    .DASH_TICKS  (DASH),
    .GAP_TICKS   (GAPT)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_in   (key_in),
    .letter   (letter),
    .valid    (valid),
    .error    (error),
    .busy     (busy)
  );

  int unsigned checks      = 0;
  int unsigned failures    = 0;
  int unsigned fail_prints = 0;

  // Reference model: run lengths of key samples and a dot/dash string table.
  string       codes [8];
  bit          m_syms [$];
  bit          m_active, m_pressing, m_done;
  int unsigned m_run;
  logic [2:0]  m_letter;
  logic        m_valid, m_error;

  int unsigned n_valid, n_error;

  task automatic model_reset();
    m_syms.delete();
    m_active   = 1'b0;
    m_pressing = 1'b0;
    m_done     = 1'b0;
    m_run      = 0;
    m_letter   = 3'b000;
    m_valid    = 1'b0;
    m_error    = 1'b0;
  endtask

  task automatic model_decode();
    string s;
    int    hit;
    s = "";
    foreach (m_syms[i]) begin
      if (m_syms[i]) s = {s, "-"};
      else           s = {s, "."};
    end
    hit = -1;
    for (int i = 0; i < 8; i++)
      if (s == codes[i]) hit = i;
    if (hit >= 0 && m_syms.size() <= 4) begin
      m_valid  = 1'b1;
      m_letter = 3'(hit);
    end else begin
      m_error = 1'b1;
    end
  endtask

  task automatic start_letter();
    m_active   = 1'b1;
    m_pressing = 1'b1;
    m_run      = 1;
    m_syms.delete();
  endtask

  task automatic model_edge(input logic k);
    m_valid = 1'b0;
    m_error = 1'b0;
    if (m_done) begin
      m_done = 1'b0;
      if (k) start_letter();
      else   m_active = 1'b0;
    end else if (!m_active) begin
      if (k) start_letter();
    end else if (m_pressing) begin
      if (k) m_run++;
      else begin
        // N high samples span (N-1)/T whole ticks inside the press.
        m_syms.push_back(((m_run - 1) / T) >= DASH);
        m_pressing = 1'b0;
        m_run      = 1;
      end
    end else begin
      if (k) begin
        m_pressing = 1'b1;
        m_run      = 1;
      end else begin
        m_run++;
        if (m_run == END_RUN) begin
          model_decode();
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic report(input string name, input int unsigned got, input int unsigned exp);
    failures++;
    if (fail_prints < 40) begin
      fail_prints++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    checks++;
    if ({letter, valid, error, busy} !== {m_letter, m_valid, m_error, m_active})
      report("cycle_outputs{letter,valid,error,busy}",
             {letter, valid, error, busy}, {m_letter, m_valid, m_error, m_active});
    if (valid === 1'b1 || error === 1'b1) begin
      checks++;
      if (valid && error) report("valid_error_exclusive", {valid, error}, 2'b10);
    end
    if (valid === 1'b1) n_valid++;
    if (error === 1'b1) n_error++;
  endtask

  task automatic cyc_step(input logic k);
    key_in = k;
    @(posedge CLOCK_50);
    model_edge(k);
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic k, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc_step(k);
  endtask

  task automatic do_reset(input int unsigned ncyc);
    key_in = 1'b0;
    reset  = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (ncyc) @(posedge CLOCK_50);
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  typedef struct {
    int unsigned n;
    int unsigned press [5];
    int unsigned gap;
    logic [2:0]  exp_letter;
    int unsigned exp_valid;
    int unsigned exp_error;
  } vec_t;

  vec_t vecs [15];

  task automatic set_vec(input int idx, input int unsigned n,
                         input int unsigned p0, input int unsigned p1, input int unsigned p2,
                         input int unsigned p3, input int unsigned p4, input int unsigned gap,
                         input logic [2:0] l, input int unsigned v, input int unsigned e);
    vecs[idx].n          = n;
    vecs[idx].press[0]   = p0;
    vecs[idx].press[1]   = p1;
    vecs[idx].press[2]   = p2;
    vecs[idx].press[3]   = p3;
    vecs[idx].press[4]   = p4;
    vecs[idx].gap        = gap;
    vecs[idx].exp_letter = l;
    vecs[idx].exp_valid  = v;
    vecs[idx].exp_error  = e;
  endtask

  initial begin
    codes[0] = ".-";   codes[1] = "-..."; codes[2] = "-.-."; codes[3] = "-..";
    codes[4] = ".";    codes[5] = "..-."; codes[6] = "--.";  codes[7] = "....";

    //          n  presses                gap letter  v  e
    set_vec( 0, 2,  4, 12,  0,  0, 0,  4, 3'b000, 1, 0);  // A
    set_vec( 1, 4, 12,  4,  4,  4, 0,  4, 3'b001, 1, 0);  // B
    set_vec( 2, 4, 12,  4, 12,  4, 0,  4, 3'b010, 1, 0);  // C
    set_vec( 3, 3, 12,  4,  4,  0, 0,  4, 3'b011, 1, 0);  // D
    set_vec( 4, 1,  4,  0,  0,  0, 0,  4, 3'b100, 1, 0);  // E
    set_vec( 5, 4,  4,  4, 12,  4, 0,  4, 3'b101, 1, 0);  // F
    set_vec( 6, 3, 12, 12,  4,  0, 0,  4, 3'b110, 1, 0);  // G
    set_vec( 7, 4,  4,  4,  4,  4, 0,  4, 3'b111, 1, 0);  // H
    set_vec( 8, 4,  4,  4,  4,  4, 0, 12, 3'b111, 1, 0);  // H, longest non-ending gap
    set_vec( 9, 2, 12, 12,  0,  0, 0,  4, 3'b111, 0, 1);  // dash-dash: no letter
    set_vec(10, 5,  4,  4,  4,  4, 4,  4, 3'b111, 0, 1);  // five dots: overflow
    set_vec(11, 2,  5,  9,  0,  0, 0,  4, 3'b000, 1, 0);  // A from dot/dash thresholds
    set_vec(12, 1,  8,  0,  0,  0, 0,  4, 3'b100, 1, 0);  // 8-cycle press is still a dot
    set_vec(13, 4, 16, 16, 16, 16, 0,  4, 3'b100, 0, 1);  // four dashes: no letter
    set_vec(14, 3, 36, 36,  4,  0, 0,  4, 3'b110, 1, 0);  // G with saturated durations

    model_reset();
    reset  = 1'b1;
    key_in = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_outputs();
    reset = 1'b0;

    for (int v = 0; v < 15; v++) begin
      n_valid = 0;
      n_error = 0;
      for (int unsigned s = 0; s < vecs[v].n; s++) begin
        hold(1'b1, vecs[v].press[s]);
        hold(1'b0, (s == vecs[v].n - 1) ? 16 : vecs[v].gap);
      end
      checks++;
      if (n_valid != vecs[v].exp_valid) report($sformatf("vec%0d_valid_pulses", v), n_valid, vecs[v].exp_valid);
      checks++;
      if (n_error != vecs[v].exp_error) report($sformatf("vec%0d_error_pulses", v), n_error, vecs[v].exp_error);
      checks++;
      if (letter !== vecs[v].exp_letter) report($sformatf("vec%0d_letter", v), letter, vecs[v].exp_letter);
    end

    // Reset in the middle of the second press of "A", then a lone dot.
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 6);
    do_reset(2);
    checks++;
    if ({letter, valid, error, busy} !== 6'b0) report("reset_mid_letter_outputs", {letter, valid, error, busy}, 0);
    n_valid = 0;
    hold(1'b1, 4);
    hold(1'b0, 16);
    checks++;
    if (letter !== 3'b100 || n_valid != 1) report("after_reset_E", {n_valid[3:0], letter}, {4'd1, 3'b100});

    // "D" with the next press landing in its DONE cycle, then "G".
    n_valid = 0;
    hold(1'b1, 12); hold(1'b0, 4);
    hold(1'b1, 4);  hold(1'b0, 4);
    hold(1'b1, 4);  hold(1'b0, END_RUN);
    checks++;
    if ({valid, letter} !== {1'b1, 3'b011}) report("done_cycle_D", {valid, letter}, {1'b1, 3'b011});
    cyc_step(1'b1);
    checks++;
    if (busy !== 1'b1) report("busy_after_done_press", busy, 1);
    hold(1'b1, 11); hold(1'b0, 4);
    hold(1'b1, 12); hold(1'b0, 4);
    hold(1'b1, 4);  hold(1'b0, 16);
    checks++;
    if (letter !== 3'b110 || n_valid != 2) report("G_after_done_press", {n_valid[3:0], letter}, {4'd2, 3'b110});

    // Random letters; every cycle is compared with the reference model.
    for (int l = 0; l < 150; l++) begin
      int unsigned nsym;
      nsym = $urandom_range(5, 1);
      for (int unsigned s = 0; s < nsym; s++) begin
        hold(1'b1, $urandom_range(14, 1));
        if (s == nsym - 1) hold(1'b0, $urandom_range(END_RUN + 5, END_RUN));
        else               hold(1'b0, $urandom_range(END_RUN - 1, 1));
      end
    end
    hold(1'b0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
